// File: rtl/prog_sequencer.sv
// prog_sequencer
//
// Steps the program counter through a short series of benchmark programs.
// The bench launches each program by raising Start and then dropping it.
// On the falling edge the sequencer loads the PC with that program's start
// address and lets it run. When the core decodes a halt, the sequencer stops
// the PC and raises Ack until the next Start rise. After the last program,
// the next Start pulse moves to a terminal FINISHED state with AllDone high.
//
// Optional feature macro: PROG_SEQUENCER_CYCLE_COUNT_EN
//   When defined, CycleCount counts the RUN cycles of the current or last
//   program, saturating at 16'hFFFF. When undefined, no counter is built
//   and CycleCount is tied to 0.
//
// Ports
//   Clk         in   clock; all state changes on the rising edge
//   Reset       in   asynchronous reset, active low
//   Start       in   bench request; a program is launched on its falling edge
//   Halt        in   core's decoded halt, honoured only in RUN
//   PcLoad      out  one-cycle pulse; the PC loads PcLoadVal at the next edge
//   PcLoadVal   out  [A-1:0] address for the PC load
//   PcHold      out  the PC must not advance while this is high
//   ProgBase    out  [A-1:0] base address of the current program
//   ProgIdx     out  [1:0] current program number 1..NPROG; 0 before the first launch
//   Ack         out  the current program has halted
//   AllDone     out  the series is complete; stays high until reset
//   CycleCount  out  [15:0] RUN cycles of the current or last program
module prog_sequencer #(
  parameter int A     = 10,
  parameter int NPROG = 3,
  parameter int BASE1 = 0,
  parameter int BASE2 = 160,
  parameter int BASE3 = 500
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Halt,
  output logic         PcLoad,
  output logic [A-1:0] PcLoadVal,
  output logic         PcHold,
  output logic [A-1:0] ProgBase,
  output logic [1:0]   ProgIdx,
  output logic         Ack,
  output logic         AllDone,
  output logic [15:0]  CycleCount
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    LAUNCH   = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    FINISHED = 3'd5
  } state_t;

  // Base addresses are truncated to the address width.
  localparam logic [A-1:0] B1 = A'(BASE1);
  localparam logic [A-1:0] B2 = A'(BASE2);
  localparam logic [A-1:0] B3 = A'(BASE3);
  localparam logic [1:0]   LAST_IDX = 2'(NPROG);

  state_t      state_reg, state_next;
  logic        start_r;
  logic        rise, fall;
  logic        launch_go;
  logic [1:0]  idx_next;
  logic [A-1:0] base_next;

  // start_r follows Start in every state. Edges that arrive in a state that
  // ignores them are therefore consumed and cannot fire later.
  assign rise     = Start & ~start_r;
  assign fall     = ~Start & start_r;
  assign idx_next = ProgIdx + 2'd1;

  always_comb begin
    base_next = B3;
    case (idx_next)
      2'd1:    base_next = B1;
      2'd2:    base_next = B2;
      default: base_next = B3;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    launch_go  = 1'b0;
    case (state_reg)
      IDLE:     if (rise) state_next = ARMED;
      ARMED: begin
        if (fall) begin
          if (ProgIdx == LAST_IDX) begin
            state_next = FINISHED;
          end else begin
            state_next = LAUNCH;
            launch_go  = 1'b1;
          end
        end
      end
      LAUNCH:   state_next = RUN;
      // Halt takes priority over any Start edge that arrives in the same cycle.
      RUN:      if (Halt) state_next = DONE;
      DONE:     if (rise) state_next = ARMED;
      FINISHED: state_next = FINISHED;
      default:  state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the state register only. No input
  // reaches an output through combinational logic.
  always_comb begin
    PcLoad  = 1'b0;
    PcHold  = 1'b1;
    Ack     = 1'b0;
    AllDone = 1'b0;
    case (state_reg)
      LAUNCH:   PcLoad  = 1'b1;
      RUN:      PcHold  = 1'b0;
      DONE:     Ack     = 1'b1;
      FINISHED: AllDone = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      start_r   <= 1'b0;
      ProgIdx   <= 2'd0;
      PcLoadVal <= '0;
      ProgBase  <= '0;
    end else begin
      state_reg <= state_next;
      start_r   <= Start;
      if (launch_go) begin
        ProgIdx   <= idx_next;
        PcLoadVal <= base_next;
        ProgBase  <= base_next;
      end
    end
  end

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
  logic [15:0] count_reg;

  // The counter clears on entry to LAUNCH, so it already reads 0 during the
  // load cycle. The increment at the edge that samples Halt is included in
  // the count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_reg <= 16'd0;
    end else if (launch_go) begin
      count_reg <= 16'd0;
    end else if (state_reg == RUN && count_reg != 16'hFFFF) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign CycleCount = count_reg;
`else
  assign CycleCount = 16'd0;
`endif

endmodule
